// File: rtl/fpga_test_pkg.sv
// Shared word type and checker state encoding for the fpga test harness.
package fpga_test_pkg;

    localparam int unsigned MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } chk_state_t;

endpackage

// File: rtl/out_channel_checker_expect_store.sv
// Expected-word register file: one write port used while loading, one async read port.
module expect_store #(
    parameter int unsigned W  = 12,
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] mem_d [N];

    // Index compare per entry keeps out-of-range read addresses (raddr == N) harmless.
    always_comb begin
        mem_d = mem_q;
        rdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (we && waddr == AW'(i)) begin
                mem_d[i] = wdata;
            end
            if (raddr == AW'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/out_channel_checker.sv
// Out-channel reader: loads an expected sequence, captures program output words,
// and reports finished/success with mismatch, timeout and overflow tracking.
module out_channel_checker #(
    parameter int unsigned MemoryElementWidth = fpga_test_pkg::MemoryElementWidth,
    parameter int unsigned NExpect            = 8,
    parameter int unsigned TimeoutCycles      = 1024,
    localparam int unsigned CW                = $clog2(NExpect + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          exp_valid,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          exp_last,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    output logic [CW-1:0]                 words_seen,
    output logic [CW-1:0]                 first_bad,
    output logic                          timed_out,
    output logic                          finished,
    output logic                          success
);

    import fpga_test_pkg::*;

    localparam logic [CW-1:0] NEXP         = CW'(NExpect);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TimeoutCycles - 1);

    chk_state_t state_q, state_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic [CW-1:0] words_seen_q, words_seen_d;
    logic [CW-1:0] first_bad_q, first_bad_d;
    logic [31:0]   timer_q, timer_d;
    logic          mismatch_q, mismatch_d;
    logic          timed_out_q, timed_out_d;
    logic          overflow_q, overflow_d;

    logic                          wr_en;
    logic [MemoryElementWidth-1:0] exp_rd;

    expect_store #(
        .W  (MemoryElementWidth),
        .N  (NExpect),
        .AW (CW)
    ) u_store (
        .clock (clock),
        .we    (wr_en),
        .waddr (load_cnt_q),
        .wdata (exp_data),
        .raddr (words_seen_q),
        .rdata (exp_rd)
    );

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        words_seen_d = words_seen_q;
        first_bad_d  = first_bad_q;
        timer_d      = timer_q;
        mismatch_d   = mismatch_q;
        timed_out_d  = timed_out_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        out_ready    = 1'b0;

        if (start) begin
            state_d      = LOAD;
            load_cnt_d   = '0;
            words_seen_d = '0;
            first_bad_d  = NEXP;
            timer_d      = '0;
            mismatch_d   = 1'b0;
            timed_out_d  = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (exp_valid && load_cnt_q != NEXP) begin
                        wr_en      = 1'b1;
                        load_cnt_d = load_cnt_q + CW'(1);
                    end
                    if (exp_last || load_cnt_d == NEXP) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    out_ready = 1'b1;
                    timer_d   = timer_q + 32'd1;
                    if (out_valid) begin
                        if (words_seen_q < load_cnt_q) begin
                            words_seen_d = words_seen_q + CW'(1);
                            if (out_data != exp_rd) begin
                                mismatch_d = 1'b1;
                                if (!mismatch_q) begin
                                    first_bad_d = words_seen_q;
                                end
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // Completion takes priority over a coincident timeout.
                    if (words_seen_d == load_cnt_q) begin
                        state_d = DONE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                    end
                end
                DONE: begin
                    out_ready = 1'b1;
                    if (out_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            load_cnt_q   <= '0;
            words_seen_q <= '0;
            first_bad_q  <= NEXP;
            timer_q      <= '0;
            mismatch_q   <= 1'b0;
            timed_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            words_seen_q <= words_seen_d;
            first_bad_q  <= first_bad_d;
            timer_q      <= timer_d;
            mismatch_q   <= mismatch_d;
            timed_out_q  <= timed_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign words_seen = words_seen_q;
    assign first_bad  = first_bad_q;
    assign timed_out  = timed_out_q;
    assign finished   = (state_q == DONE);
    assign success    = finished && !mismatch_q && !timed_out_q && !overflow_q;

endmodule
